pipe_stage_elastic: RTL and testbench

//  Parametrised elastic pipeline stage register; successor to the fixed MEM/WB latch.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_stage_elastic_if.sv | 27 ++
 rtl/pipe_entry_reg.sv | 51 +++++
 rtl/pipe_stage_elastic.sv | 115 +++++++++++
 tb/tb_pipe_stage_elastic.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared encodings and defaults for the elastic pipeline stage
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

    localparam int CTRL_W_DEF = 8;
    // 32 PC+4, 32 ALU result, 32 memory read data, 5 WB register, 5 Rt
    localparam int DATA_W_DEF = 106;

    localparam int CTRL_REGDST   = 0;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_REGWR    = 2;

    localparam int CTRL_BUBBLE = 0;

endpackage

// File: rtl/pipe_stage_elastic_if.sv
// rtl/pipe_stage_elastic_if.sv - upstream/downstream handshake bundle of one pipeline stage
interface pipe_stage_elastic_if
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;

    // master is the surrounding pipeline, slave is the stage itself
    modport master (
        output in_valid, in_ctrl, in_data, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data
    );

    modport slave (
        input  in_valid, in_ctrl, in_data, out_ready,
        output in_ready, out_valid, out_ctrl, out_data
    );
endinterface

// File: rtl/pipe_entry_reg.sv
// rtl/pipe_entry_reg.sv - one held entry: valid + ctrl + data with load enable and async clear
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              valid_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);
    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Payload only loads with a valid entry so a drained register keeps its last data
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (en) begin
            valid_d = valid_in;
            if (valid_in) begin
                ctrl_d = ctrl_in;
                data_d = data_in;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign ctrl  = ctrl_q;
    assign data  = data_q;
endmodule

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic pipeline stage with skid buffer, flush and bubble insertion
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter bit SKID   = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    pipe_stage_elastic_if.slave  bus,
    output logic [1:0]           occupancy
);
    pipe_state_e state_q, state_d;

    logic              head_en, head_valid_in, head_from_skid;
    logic              skid_en, skid_valid_in;
    logic              head_valid, skid_valid;
    logic [CTRL_W-1:0] head_ctrl, skid_ctrl, head_ctrl_in;
    logic [DATA_W-1:0] head_data, skid_data, head_data_in;
    logic              in_ready, accept, consume;

    // With the skid buffer in_ready comes straight from the state flop, so there is
    // no combinational path from out_ready back upstream.
    assign in_ready = SKID ? (state_q != ST_FULL) : (!head_valid || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign consume  = head_valid && bus.out_ready;

    always_comb begin
        state_d        = state_q;
        head_en        = 1'b0;
        head_valid_in  = 1'b0;
        head_from_skid = 1'b0;
        skid_en        = 1'b0;
        skid_valid_in  = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
            head_en = 1'b1;
            skid_en = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d       = ST_ONE;
                        head_en       = 1'b1;
                        head_valid_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        head_en       = 1'b1;
                        head_valid_in = 1'b1;
                    end else if (accept) begin
                        state_d       = ST_FULL;
                        skid_en       = 1'b1;
                        skid_valid_in = 1'b1;
                    end else if (consume) begin
                        state_d = ST_EMPTY;
                        head_en = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (consume) begin
                        state_d        = ST_ONE;
                        head_en        = 1'b1;
                        head_valid_in  = 1'b1;
                        head_from_skid = 1'b1;
                        skid_en        = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_EMPTY;
        else        state_q <= state_d;
    end

    assign head_ctrl_in = head_from_skid ? skid_ctrl : bus.in_ctrl;
    assign head_data_in = head_from_skid ? skid_data : bus.in_data;

    pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_head (
        .clk      (clk),
        .reset    (reset),
        .en       (head_en),
        .valid_in (head_valid_in),
        .ctrl_in  (head_ctrl_in),
        .data_in  (head_data_in),
        .valid    (head_valid),
        .ctrl     (head_ctrl),
        .data     (head_data)
    );

    pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk      (clk),
        .reset    (reset),
        .en       (skid_en),
        .valid_in (skid_valid_in),
        .ctrl_in  (bus.in_ctrl),
        .data_in  (bus.in_data),
        .valid    (skid_valid),
        .ctrl     (skid_ctrl),
        .data     (skid_data)
    );

    // An empty head must look like a bubble downstream (RegWr and friends low)
    assign bus.out_ctrl  = head_valid ? head_ctrl : CTRL_W'(CTRL_BUBBLE);
    assign bus.out_data  = head_data;
    assign bus.out_valid = head_valid;
    assign bus.in_ready  = in_ready;
    assign occupancy     = {skid_valid, head_valid && !skid_valid} | state_q;
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - directed bench for pipe_stage_elastic (SKID=1 and SKID=0)
module tb_pipe_stage_elastic;
    localparam int CW = 8;
    localparam int DW = 106;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic [1:0] occ0, occ1;
    int         errors = 0;
    int         checks = 0;

    pipe_stage_elastic_if #(.CTRL_W(CW), .DATA_W(DW)) bus0 ();
    pipe_stage_elastic_if #(.CTRL_W(CW), .DATA_W(DW)) bus1 ();

    pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1)) dut0 (
        .clk(clk), .reset(reset), .flush(flush), .bus(bus0), .occupancy(occ0));
    pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b0)) dut1 (
        .clk(clk), .reset(reset), .flush(flush), .bus(bus1), .occupancy(occ1));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [CW-1:0] c, input int d, input logic rdy);
        bus0.in_valid  = v;
        bus0.in_ctrl   = c;
        bus0.in_data   = DW'(d);
        bus0.out_ready = rdy;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        flush = 1'b0;
        drive0(1'b0, 8'h00, 0, 1'b0);
        bus1.in_valid = 1'b0; bus1.in_ctrl = '0; bus1.in_data = '0; bus1.out_ready = 1'b0;
        #1;
        checks++; if (bus0.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", bus0.out_valid); end
        checks++; if (bus0.out_ctrl !== 8'h00) begin errors++; $display("FAIL rst_ctrl got=%h exp=00", bus0.out_ctrl); end
        checks++; if (bus0.out_data !== DW'(0)) begin errors++; $display("FAIL rst_data got=%h exp=0", bus0.out_data); end
        checks++; if (occ0 !== 2'd0) begin errors++; $display("FAIL rst_occ got=%0d exp=0", occ0); end
        step(); step();
        @(negedge clk) reset = 1'b1;
        step();
        checks++; if (bus0.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", bus0.in_ready); end
    endtask

    task automatic test_streaming();
        for (int i = 1; i <= 4; i++) begin
            drive0(1'b1, 8'h01, i, 1'b1);
            step();
            checks++; if (bus0.out_valid !== 1'b1 || bus0.out_data !== DW'(i)) begin
                errors++; $display("FAIL stream_data[%0d] got=%h v=%b exp=%0d", i, bus0.out_data, bus0.out_valid, i); end
            checks++; if (bus0.in_ready !== 1'b1 || occ0 !== 2'd1) begin
                errors++; $display("FAIL stream_ready[%0d] rdy=%b occ=%0d exp rdy=1 occ=1", i, bus0.in_ready, occ0); end
        end
        drive0(1'b0, 8'h01, 0, 1'b1);
        step();
        checks++; if (bus0.out_valid !== 1'b0 || occ0 !== 2'd0) begin
            errors++; $display("FAIL stream_drain v=%b occ=%0d exp v=0 occ=0", bus0.out_valid, occ0); end
    endtask

    task automatic test_backpressure();
        drive0(1'b1, 8'h11, 'h10, 1'b0);
        step();
        checks++; if (occ0 !== 2'd1 || bus0.out_data !== DW'('h10) || bus0.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_a occ=%0d data=%h rdy=%b exp occ=1 data=10 rdy=1", occ0, bus0.out_data, bus0.in_ready); end
        drive0(1'b1, 8'h22, 'h20, 1'b0);
        step();
        checks++; if (occ0 !== 2'd2 || bus0.in_ready !== 1'b0 || bus0.out_data !== DW'('h10)) begin
            errors++; $display("FAIL bp_full occ=%0d rdy=%b data=%h exp occ=2 rdy=0 data=10", occ0, bus0.in_ready, bus0.out_data); end
        drive0(1'b0, 8'h00, 0, 1'b1);
        step();
        checks++; if (bus0.out_data !== DW'('h20) || bus0.out_ctrl !== 8'h22 || bus0.in_ready !== 1'b1 || occ0 !== 2'd1) begin
            errors++; $display("FAIL bp_b data=%h ctrl=%h rdy=%b occ=%0d exp data=20 ctrl=22 rdy=1 occ=1",
                bus0.out_data, bus0.out_ctrl, bus0.in_ready, occ0); end
        step();
        checks++; if (bus0.out_valid !== 1'b0 || bus0.out_ctrl !== 8'h00 || occ0 !== 2'd0) begin
            errors++; $display("FAIL bp_empty v=%b ctrl=%h occ=%0d exp v=0 ctrl=00 occ=0", bus0.out_valid, bus0.out_ctrl, occ0); end
    endtask

    task automatic test_flush();
        drive0(1'b1, 8'h11, 'h10, 1'b0); step();
        drive0(1'b1, 8'h22, 'h20, 1'b0); step();
        checks++; if (occ0 !== 2'd2) begin errors++; $display("FAIL fl_fill occ=%0d exp=2", occ0); end
        drive0(1'b1, 8'h33, 'h30, 1'b0);
        flush = 1'b1;
        step();
        checks++; if (bus0.out_valid !== 1'b0 || bus0.out_ctrl !== 8'h00 || occ0 !== 2'd0) begin
            errors++; $display("FAIL fl_full v=%b ctrl=%h occ=%0d exp v=0 ctrl=00 occ=0", bus0.out_valid, bus0.out_ctrl, occ0); end
        checks++; if (bus0.out_data !== DW'('h10)) begin
            errors++; $display("FAIL fl_data_held got=%h exp=10", bus0.out_data); end
        flush = 1'b0;
        drive0(1'b0, 8'h00, 0, 1'b0);
        step();
        checks++; if (bus0.out_valid !== 1'b0 || occ0 !== 2'd0) begin
            errors++; $display("FAIL fl_after v=%b occ=%0d exp v=0 occ=0", bus0.out_valid, occ0); end
        drive0(1'b1, 8'h44, 'h40, 1'b0); step();
        drive0(1'b1, 8'h33, 'h30, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive0(1'b0, 8'h00, 0, 1'b1);
        checks++; if (bus0.out_valid !== 1'b0 || occ0 !== 2'd0 || bus0.out_data !== DW'('h40)) begin
            errors++; $display("FAIL fl_accept_drop v=%b occ=%0d data=%h exp v=0 occ=0 data=40", bus0.out_valid, occ0, bus0.out_data); end
        step();
        checks++; if (bus0.out_valid !== 1'b0) begin errors++; $display("FAIL fl_no_c v=%b exp=0", bus0.out_valid); end
    endtask

    task automatic test_bubble();
        drive0(1'b1, 8'hFF, 'h55, 1'b1);
        step();
        checks++; if (bus0.out_valid !== 1'b1 || bus0.out_ctrl !== 8'hFF) begin
            errors++; $display("FAIL bub_load v=%b ctrl=%h exp v=1 ctrl=ff", bus0.out_valid, bus0.out_ctrl); end
        drive0(1'b0, 8'hFF, 'h55, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus0.out_valid !== 1'b0 || bus0.out_ctrl !== 8'h00 || bus0.out_data !== DW'('h55)) begin
                errors++; $display("FAIL bubble[%0d] v=%b ctrl=%h data=%h exp v=0 ctrl=00 data=55",
                    i, bus0.out_valid, bus0.out_ctrl, bus0.out_data); end
        end
    endtask

    task automatic test_reset_midstream();
        drive0(1'b1, 8'h61, 'h61, 1'b0); step();
        drive0(1'b1, 8'h62, 'h62, 1'b0); step();
        checks++; if (occ0 !== 2'd2) begin errors++; $display("FAIL rm_fill occ=%0d exp=2", occ0); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (bus0.out_valid !== 1'b0 || bus0.out_ctrl !== 8'h00 || occ0 !== 2'd0 || bus0.out_data !== DW'(0)) begin
            errors++; $display("FAIL rm_async v=%b ctrl=%h occ=%0d data=%h exp all 0",
                bus0.out_valid, bus0.out_ctrl, occ0, bus0.out_data); end
        @(negedge clk);
        reset = 1'b1;
        drive0(1'b0, 8'h00, 0, 1'b0);
        step();
        checks++; if (bus0.in_ready !== 1'b1 || bus0.out_valid !== 1'b0) begin
            errors++; $display("FAIL rm_release rdy=%b v=%b exp rdy=1 v=0", bus0.in_ready, bus0.out_valid); end
    endtask

    task automatic test_skid0();
        int exp_data [5] = '{5, 5, 6, 7, 0};
        logic exp_v [5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int in_d [5]     = '{5, 6, 6, 7, 0};
        logic in_v [5]   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic rdy [5]    = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            bus1.in_valid  = in_v[i];
            bus1.in_ctrl   = 8'h07;
            bus1.in_data   = DW'(in_d[i]);
            bus1.out_ready = rdy[i];
            #1;
            if (i == 1) begin
                checks++; if (bus1.in_ready !== 1'b0) begin
                    errors++; $display("FAIL s0_comb_ready got=%b exp=0", bus1.in_ready); end
            end
            step();
            checks++; if (bus1.out_valid !== exp_v[i] || (exp_v[i] && bus1.out_data !== DW'(exp_data[i]))) begin
                errors++; $display("FAIL s0_seq[%0d] v=%b data=%h exp v=%b data=%0d",
                    i, bus1.out_valid, bus1.out_data, exp_v[i], exp_data[i]); end
            checks++; if (occ1 > 2'd1) begin errors++; $display("FAIL s0_occ[%0d] got=%0d exp<=1", i, occ1); end
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_bubble();
        test_reset_midstream();
        test_skid0();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
